// File: rtl/dft_sched_pkg.sv
// Shared types and constants for the DFT frame scheduler.
package dft_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        STREAM = 2'd2,
        GAP    = 2'd3
    } sched_state_t;

    // Legal DFT sizes accepted by the mixed-radix core
    localparam int MIN_PTS = 12;
    localparam int MAX_PTS = 1200;

    // Width of a requester ID; never narrower than one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dft_tag_fifo.sv
// Synchronous FIFO of requester IDs: one entry per frame in flight inside the DFT.
module dft_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; push and pop may both happen in one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: the tag memory is reset because its head drives out_id, which must read 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dft_frame_sched.sv
// Round-robin job scheduler and frame sequencer in front of the mixed-radix DFT.
// Optional statistics counters are built when DFT_FRAME_SCHED_STATS_EN is defined.
module dft_frame_sched
    import dft_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 18,
    parameter int PTS_W   = 12,
    parameter int MAX_OUT = 4,
    parameter int GAP_CYC = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*PTS_W-1:0]         req_pts,
    input  logic [NREQ-1:0]               req_inverse,
    output logic [NREQ-1:0]               req_grant,
    output logic [NREQ-1:0]               smp_rd,
    input  logic [NREQ*DATA_W-1:0]        smp_real,
    input  logic [NREQ*DATA_W-1:0]        smp_imag,
    output logic                          sink_valid,
    output logic                          sink_sop,
    output logic                          sink_eop,
    output logic [DATA_W-1:0]             sink_real,
    output logic [DATA_W-1:0]             sink_imag,
    output logic [PTS_W-1:0]              dftpts_in,
    output logic                          inverse,
    input  logic                          sink_ready,
    input  logic                          source_valid,
    input  logic                          source_sop,
    input  logic                          source_eop,
    output logic [id_width(NREQ)-1:0]     out_id,
    output logic                          err_size,
    output logic                          err_orphan
`ifdef DFT_FRAME_SCHED_STATS_EN
    ,
    output logic [NREQ*32-1:0]            stat_frames,
    output logic [31:0]                   stat_stall
`endif
);

    localparam int ID_W  = id_width(NREQ);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    sched_state_t     state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  job_id;
    logic [PTS_W-1:0] job_pts;
    logic             job_inv;
    logic [PTS_W-1:0] smp_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic             pick_valid;
    logic [ID_W-1:0]  pick_id;
    logic [ID_W-1:0]  rr_idx;
    logic [NREQ-1:0]  pick_onehot;
    logic [PTS_W-1:0] pick_pts;
    logic             pick_inv;
    logic [DATA_W-1:0] cur_real;
    logic [DATA_W-1:0] cur_imag;

    logic             size_ok;
    logic             tag_push;
    logic             tag_pop;
    logic             tag_full;
    logic             tag_empty;
    logic [ID_W-1:0]  tag_head;
    logic [$clog2(MAX_OUT):0] unused_tag_count;
    logic             unused_sop;

    assign size_ok    = (job_pts >= PTS_W'(MIN_PTS)) && (job_pts <= PTS_W'(MAX_PTS));
    assign tag_push   = (state == ARB) && size_ok;
    assign tag_pop    = source_valid && source_eop;
    assign out_id     = tag_head;
    assign unused_sop = source_sop;

    // Round-robin pick starting after the last granted index, plus per-requester muxes
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        pick_valid  = 1'b0;
        pick_id     = '0;
        rr_idx      = '0;
        pick_onehot = '0;
        pick_pts    = '0;
        pick_inv    = 1'b0;
        cur_real    = '0;
        cur_imag    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = ID_W'((int'(rr_ptr) + k) % NREQ);
            if (!pick_valid && req_valid[rr_idx]) begin
                pick_valid = 1'b1;
                pick_id    = rr_idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            pick_onehot[i] = (pick_id == ID_W'(i));
            if (pick_id == ID_W'(i)) begin
                pick_pts = req_pts[i*PTS_W +: PTS_W];
                pick_inv = req_inverse[i];
            end
            if (job_id == ID_W'(i)) begin
                cur_real = smp_real[i*DATA_W +: DATA_W];
                cur_imag = smp_imag[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pop the show-ahead sample of the active requester whenever the DFT can take it
    always_comb begin
        smp_rd = '0;
        for (int i = 0; i < NREQ; i++) begin
            smp_rd[i] = (state == STREAM) && sink_ready && (job_id == ID_W'(i));
        end
    end

    // Scheduler FSM with registered grant, framing and sample outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= ID_W'(NREQ - 1);
            job_id     <= '0;
            job_pts    <= '0;
            job_inv    <= 1'b0;
            smp_cnt    <= '0;
            gap_cnt    <= '0;
            req_grant  <= '0;
            err_size   <= 1'b0;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            sink_real  <= '0;
            sink_imag  <= '0;
            dftpts_in  <= '0;
            inverse    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
            req_grant  <= '0;
            err_size   <= 1'b0;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid && !tag_full) begin
                        state     <= ARB;
                        req_grant <= pick_onehot;
                        job_id    <= pick_id;
                        job_pts   <= pick_pts;
                        job_inv   <= pick_inv;
                        rr_ptr    <= pick_id;
                    end
                end
                ARB: begin
                    if (size_ok) begin
                        state     <= STREAM;
                        dftpts_in <= job_pts;
                        inverse   <= job_inv;
                        smp_cnt   <= '0;
                    end else begin
                        err_size <= 1'b1;
                        state    <= IDLE;
                    end
                end
                STREAM: begin
                    if (sink_ready) begin
                        sink_valid <= 1'b1;
                        sink_real  <= cur_real;
                        sink_imag  <= cur_imag;
                        sink_sop   <= (smp_cnt == '0);
                        sink_eop   <= (smp_cnt == job_pts - PTS_W'(1));
                        if (smp_cnt == job_pts - PTS_W'(1)) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else begin
                            smp_cnt <= smp_cnt + PTS_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flag: DFT produced output while no frame tag was outstanding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_orphan <= 1'b0;
        end else if (source_valid && tag_empty) begin
            err_orphan <= 1'b1;
        end
    end

    dft_tag_fifo #(
        .DEPTH (MAX_OUT),
        .W     (ID_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_push),
        .push_data (job_id),
        .pop       (tag_pop),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (unused_tag_count)
    );

`ifdef DFT_FRAME_SCHED_STATS_EN
    // Saturating accepted-frame counters per requester and a stream stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_frames <= '0;
            stat_stall  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (tag_push && (job_id == ID_W'(i)) && (stat_frames[i*32 +: 32] != '1)) begin
                    stat_frames[i*32 +: 32] <= stat_frames[i*32 +: 32] + 32'd1;
                end
            end
            if ((state == STREAM) && !sink_ready && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dft_frame_sched.md
# dft_frame_sched

Front-end scheduler for `top_mixed_radix_dft_0`: arbitrates DFT jobs from NREQ requesters, streams each granted frame into the DFT sink port with correct sop/eop/dftpts/inverse framing, and tags DFT output frames with the originating requester ID. It sits between the per-antenna/per-layer sample buffers and the mixed-radix DFT core. It replaces ad-hoc frame generation with a round-robin, backpressure-aware, bounded-outstanding sequencer.

## Interface
- NREQ, 4, number of requesters (2..8)
- DATA_W, 18, sample component width
- PTS_W, 12, DFT size field width
- MAX_OUT, 4, max frames in flight inside the DFT (power of 2)
- GAP_CYC, 8, minimum idle cycles between sink_eop and next sink_sop
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  requester i has a job pending
- req_pts  in  NREQ*PTS_W  job size per requester, held while req_valid
- req_inverse  in  NREQ  IDFT select per requester
- req_grant  out  NREQ  one-hot, 1-cycle pulse: job accepted
- smp_rd  out  NREQ  pop one sample from requester i (show-ahead data)
- smp_real, smp_imag  in  NREQ*DATA_W  show-ahead sample per requester
- sink_valid/sink_sop/sink_eop  out  1 each  to DFT
- sink_real/sink_imag  out  DATA_W  to DFT
- dftpts_in  out  PTS_W  to DFT, constant for the frame
- inverse  out  1  to DFT, constant for the frame
- sink_ready  in  1  from DFT
- source_valid/source_sop/source_eop  in  1 each  from DFT output
- out_id  out  $clog2(NREQ)  requester ID of current DFT output frame
- err_size  out  1  pulse: job rejected for illegal size
- err_orphan  out  1  sticky: DFT output with no tag outstanding

## Operation
- FSM states: IDLE, ARB, STREAM, GAP.
- IDLE -> ARB when any req_valid and tag FIFO not full.
- ARB (1 cycle): round-robin pick starting after last granted index; pulse req_grant; latch pts/inverse/ID. If pts < 12 or pts > 1200: pulse err_size, no tag push, -> IDLE (requester still sees grant and drops job). Else push ID to tag FIFO, -> STREAM.
- STREAM: in each cycle with sink_ready=1, assert smp_rd[id] and issue one sample; sample counter 0..pts-1. After issuing sample pts-1 -> GAP.
- GAP: count GAP_CYC cycles, then -> IDLE. dftpts_in/inverse hold last value until next ARB.
- Tag FIFO (depth MAX_OUT): pop on source_valid & source_eop. out_id = head entry. source_valid with FIFO empty sets err_orphan until reset.
- Round-robin pointer updates only on grant (including rejected grants).

## Timing
- All sink_* outputs registered; smp_rd combinational from state & sink_ready.
- Sample popped in cycle t appears on sink_real/imag with sink_valid in t+1.
- sink_sop with sample 0; sink_eop with sample pts-1 (same cycle if pts=1, never legal).
- sink_ready low: no smp_rd, sink_valid=0 next cycle; counter holds.
- Grant to first sink_valid: 2 cycles minimum (ARB, STREAM-issue, register).
- Simultaneous tag push and pop: both take effect; count unchanged.
- Reset values: sink_* 0, dftpts_in 0, inverse 0, req_grant 0, smp_rd 0, out_id 0, err flags 0, RR pointer to NREQ-1 (req 0 wins first), FIFO empty, state IDLE. Reset mid-frame truncates the frame with no eop; DFT must be reset together.

## Configuration
- DFT_FRAME_SCHED_STATS_EN defined: adds 32-bit saturating per-requester frame counters and a stall counter (cycles in STREAM with sink_ready=0), exposed as stat_frames (NREQ*32) and stat_stall (32), reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

## Structure
- Package dft_sched_pkg: state enum, MIN_PTS=12, MAX_PTS=1200, ID width function.
- Sub-module dft_tag_fifo: synchronous FIFO of IDs with full/empty/count; instantiated once.

## Test plan
- Single requester 0, pts=1200, sink_ready=1 -> one grant, 1200 sink_valid cycles, sop on first, eop on 1200th, dftpts_in=1200, then ≥8 idle cycles.
- Requesters 0..3 all valid, pts=12 -> grants in order 0,1,2,3,0; out_id follows 0,1,2,3 on DFT outputs.
- pts=1300 on requester 2 -> err_size pulse, no sink activity, no tag push, next requester served.
- sink_ready toggling 1/0 each cycle, pts=24 -> 24 samples delivered in order, no duplicates or drops, 48±2 cycles span.
- Five frames issued with DFT output stalled -> fifth grant withheld until first source_eop.
- source_valid injected with no job -> err_orphan set and held until rst_n low.
